// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with per-set LRU ages.
// Misses evict a victim line, write it back if dirty, then refill it one word at a time.
module cache_nway #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned WAY_NUM     = 4,
  parameter int unsigned CACHE_LINES = 128,
  parameter int unsigned WORD_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]  adr_cpu2cc,
  input  logic [WORD_WIDTH-1:0] dat_cpu2cc,
  input  logic                  rdwr_cpu2cc,
  output logic                  ack_cc2cpu,
  output logic [WORD_WIDTH-1:0] dat_cc2cpu,
  output logic                  req_cc2mem,
  output logic                  rdwr_cc2mem,
  output logic [ADR_WIDTH-1:0]  adr_cc2mem,
  output logic [WORD_WIDTH-1:0] dat_cc2mem,
  input  logic                  ack_mem2cc,
  input  logic [WORD_WIDTH-1:0] dat_mem2cc
);

  localparam int unsigned WOFF  = $clog2(WORD_NUM);
  localparam int unsigned INDEX = $clog2(CACHE_LINES);
  localparam int unsigned TAG   = ADR_WIDTH - INDEX - WOFF - 2;
  localparam int unsigned AGE   = $clog2(WAY_NUM);

  typedef enum logic [2:0] {StIdle, StLookup, StHit, StWriteback, StRefill} state_e;

  state_e                state_q;
  logic [TAG-1:0]        tag_q   [CACHE_LINES][WAY_NUM];
  logic [WAY_NUM-1:0]    valid_q [CACHE_LINES];
  logic [WAY_NUM-1:0]    dirty_q [CACHE_LINES];
  logic [AGE-1:0]        age_q   [CACHE_LINES][WAY_NUM];
  logic [WORD_WIDTH-1:0] data_q  [CACHE_LINES][WAY_NUM][WORD_NUM];

  // Snapshot of the addressed set taken when the request is accepted.
  logic [TAG-1:0]        set_tag_q [WAY_NUM];
  logic [WAY_NUM-1:0]    set_valid_q;
  logic [WAY_NUM-1:0]    set_dirty_q;

  logic [AGE-1:0]        way_q;
  logic [AGE-1:0]        victim_q;
  logic [WOFF-1:0]       word_q;

  logic [TAG-1:0]        req_tag;
  logic [INDEX-1:0]      req_idx;
  logic [WOFF-1:0]       req_woff;
  logic                  unused_byte;

  assign req_tag     = adr_cpu2cc[ADR_WIDTH-1 -: TAG];
  assign req_idx     = adr_cpu2cc[WOFF+2 +: INDEX];
  assign req_woff    = adr_cpu2cc[2 +: WOFF];
  assign unused_byte = ^adr_cpu2cc[1:0];

  logic            hit;
  logic [AGE-1:0]  hit_way;
  logic [AGE-1:0]  victim;
  logic            found_invalid;
  logic [AGE-1:0]  hit_age;
  logic [WOFF-1:0] word_nxt;
  logic            word_last;

  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    victim        = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!hit && set_valid_q[w] && (set_tag_q[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE'(w);
      end
    end
    // Lowest invalid way wins; otherwise the way holding the maximum age.
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!set_valid_q[w]) begin
        victim        = AGE'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (age_q[req_idx][w] == AGE'(WAY_NUM - 1)) victim = AGE'(w);
      end
    end
  end

  assign hit_age   = age_q[req_idx][way_q];
  assign word_nxt  = word_q + WOFF'(1);
  assign word_last = (word_q == WOFF'(WORD_NUM - 1));

  function automatic logic [ADR_WIDTH-1:0] line_adr(input logic [TAG-1:0]   t,
                                                    input logic [INDEX-1:0] i,
                                                    input logic [WOFF-1:0]  w);
    return {t, i, w, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_q      <= '0;
      way_q       <= '0;
      victim_q    <= '0;
      set_valid_q <= '0;
      set_dirty_q <= '0;
      ack_cc2cpu  <= 1'b0;
      dat_cc2cpu  <= '0;
      req_cc2mem  <= 1'b0;
      rdwr_cc2mem <= 1'b0;
      adr_cc2mem  <= '0;
      dat_cc2mem  <= '0;
      for (int w = 0; w < WAY_NUM; w++) set_tag_q[w] <= '0;
      for (int s = 0; s < CACHE_LINES; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAY_NUM; w++) age_q[s][w] <= AGE'(w);
      end
    end else begin
      case (state_q)
        StIdle: begin
          ack_cc2cpu <= 1'b0;
          // The ack cycle is skipped so a still-held request is not replayed.
          if (req_cpu2cc && !ack_cc2cpu) begin
            for (int w = 0; w < WAY_NUM; w++) set_tag_q[w] <= tag_q[req_idx][w];
            set_valid_q <= valid_q[req_idx];
            set_dirty_q <= dirty_q[req_idx];
            state_q     <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            way_q   <= hit_way;
            state_q <= StHit;
          end else begin
            victim_q <= victim;
            word_q   <= '0;
            state_q  <= (set_valid_q[victim] && set_dirty_q[victim]) ? StWriteback : StRefill;
          end
        end
        StHit: begin
          ack_cc2cpu <= 1'b1;
          if (rdwr_cpu2cc) begin
            data_q[req_idx][way_q][req_woff] <= dat_cpu2cc;
            dirty_q[req_idx][way_q]          <= 1'b1;
          end else begin
            dat_cc2cpu <= data_q[req_idx][way_q][req_woff];
          end
          for (int w = 0; w < WAY_NUM; w++) begin
            if (AGE'(w) == way_q) age_q[req_idx][w] <= '0;
            else if (age_q[req_idx][w] < hit_age) age_q[req_idx][w] <= age_q[req_idx][w] + AGE'(1);
          end
          state_q <= StIdle;
        end
        StWriteback: begin
          if (!req_cc2mem) begin
            req_cc2mem  <= 1'b1;
            rdwr_cc2mem <= 1'b1;
            adr_cc2mem  <= line_adr(set_tag_q[victim_q], req_idx, word_q);
            dat_cc2mem  <= data_q[req_idx][victim_q][word_q];
          end else if (ack_mem2cc) begin
            word_q <= word_nxt;
            if (word_last) begin
              req_cc2mem <= 1'b0;
              state_q    <= StRefill;
            end else begin
              adr_cc2mem <= line_adr(set_tag_q[victim_q], req_idx, word_nxt);
              dat_cc2mem <= data_q[req_idx][victim_q][word_nxt];
            end
          end
        end
        StRefill: begin
          if (!req_cc2mem) begin
            req_cc2mem  <= 1'b1;
            rdwr_cc2mem <= 1'b0;
            adr_cc2mem  <= line_adr(req_tag, req_idx, word_q);
          end else if (ack_mem2cc) begin
            data_q[req_idx][victim_q][word_q] <= dat_mem2cc;
            word_q <= word_nxt;
            if (word_last) begin
              req_cc2mem                 <= 1'b0;
              valid_q[req_idx][victim_q] <= 1'b1;
              dirty_q[req_idx][victim_q] <= 1'b0;
              tag_q[req_idx][victim_q]   <= req_tag;
              way_q                      <= victim_q;
              state_q                    <= StHit;
            end else begin
              adr_cc2mem <= line_adr(req_tag, req_idx, word_nxt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: hits, misses, LRU eviction with writeback, random memory
// latency and reset in the middle of a refill, against a behavioural word memory.
module tb_cache_nway;

  logic        clk;
  logic        rst;
  logic        req_cpu2cc;
  logic [31:0] adr_cpu2cc;
  logic [31:0] dat_cpu2cc;
  logic        rdwr_cpu2cc;
  logic        ack_cc2cpu;
  logic [31:0] dat_cc2cpu;
  logic        req_cc2mem;
  logic        rdwr_cc2mem;
  logic [31:0] adr_cc2mem;
  logic [31:0] dat_cc2mem;
  logic        ack_mem2cc;
  logic [31:0] dat_mem2cc;

  cache_nway dut (
    .clk         (clk),
    .rst         (rst),
    .req_cpu2cc  (req_cpu2cc),
    .adr_cpu2cc  (adr_cpu2cc),
    .dat_cpu2cc  (dat_cpu2cc),
    .rdwr_cpu2cc (rdwr_cpu2cc),
    .ack_cc2cpu  (ack_cc2cpu),
    .dat_cc2cpu  (dat_cc2cpu),
    .req_cc2mem  (req_cc2mem),
    .rdwr_cc2mem (rdwr_cc2mem),
    .adr_cc2mem  (adr_cc2mem),
    .dat_cc2mem  (dat_cc2mem),
    .ack_mem2cc  (ack_mem2cc),
    .dat_mem2cc  (dat_mem2cc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  // Memory model state and transaction log.
  logic [31:0] mem_q [logic [31:0]];
  bit          log_rw  [$];
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  bit          mem_rand  = 1'b0;
  int          mem_fixed = 0;
  int          unstable  = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_burst(input string tag, input int start, input bit rw,
                             input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] got;
      got = '1;
      if (start + i < log_adr.size()) got = {31'b0, log_rw[start+i], log_adr[start+i]};
      check($sformatf("%s_w%0d", tag, i), got, {31'b0, rw, base + 32'(4 * i)});
    end
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rdata, output int lat);
    int cyc;
    cyc         = 0;
    req_cpu2cc  = 1'b1;
    rdwr_cpu2cc = wr;
    adr_cpu2cc  = a;
    dat_cpu2cc  = d;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_cc2cpu && cyc < 400);
    rdata = dat_cc2cpu;
    lat   = cyc - 1;
    check($sformatf("ack_%h", a), {63'b0, ack_cc2cpu}, 64'd1);
    req_cpu2cc = 1'b0;
    @(negedge clk);
    check($sformatf("ack_pulse_%h", a), {63'b0, ack_cc2cpu}, 64'd0);
  endtask

  // Word memory: one-cycle ack pulse after a programmable delay, sampled on negedges.
  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] h_adr;
    logic [31:0] h_dat;
    bit          h_rw;
    busy       = 1'b0;
    cnt        = 0;
    h_adr      = '0;
    h_dat      = '0;
    h_rw       = 1'b0;
    ack_mem2cc = 1'b0;
    dat_mem2cc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_mem2cc = 1'b0;
        busy       = 1'b0;
      end else if (ack_mem2cc) begin
        ack_mem2cc = 1'b0;
      end else if (req_cc2mem) begin
        if (!busy) begin
          busy  = 1'b1;
          cnt   = mem_rand ? int'($urandom_range(0, 5)) : mem_fixed;
          h_adr = adr_cc2mem;
          h_rw  = rdwr_cc2mem;
          h_dat = dat_cc2mem;
        end else if (adr_cc2mem != h_adr || rdwr_cc2mem != h_rw ||
                     (h_rw && dat_cc2mem != h_dat)) begin
          unstable++;
        end
        if (cnt == 0) begin
          busy       = 1'b0;
          ack_mem2cc = 1'b1;
          log_rw.push_back(rdwr_cc2mem);
          log_adr.push_back(adr_cc2mem);
          log_dat.push_back(dat_cc2mem);
          if (rdwr_cc2mem) mem_q[adr_cc2mem] = dat_cc2mem;
          else dat_mem2cc = mem_rd(adr_cc2mem);
        end else begin
          cnt--;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] prev;
    int          lat;
    int          base;
    bit          found;

    rst         = 1'b1;
    req_cpu2cc  = 1'b0;
    rdwr_cpu2cc = 1'b0;
    adr_cpu2cc  = '0;
    dat_cpu2cc  = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {63'b0, ack_cc2cpu}, 64'd0);
    check("rst_req", {63'b0, req_cc2mem}, 64'd0);
    check("rst_rdwr", {63'b0, rdwr_cc2mem}, 64'd0);
    check("rst_adr", {32'b0, adr_cc2mem}, 64'd0);
    check("rst_dat_mem", {32'b0, dat_cc2mem}, 64'd0);
    check("rst_dat_cpu", {32'b0, dat_cc2cpu}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read miss, then hit on the same line.
    base = log_adr.size();
    cpu_access(1'b0, 32'h40, '0, rd, lat);
    check("miss_data", {32'b0, rd}, {32'b0, init_val(32'h40)});
    check("miss_traffic", 64'(log_adr.size() - base), 64'd4);
    check_burst("refill_40", base, 1'b0, 32'h40);

    base = log_adr.size();
    cpu_access(1'b0, 32'h40, '0, rd, lat);
    check("hit_lat", 64'(lat), 64'd2);
    check("hit_data", {32'b0, rd}, {32'b0, init_val(32'h40)});
    check("hit_traffic", 64'(log_adr.size() - base), 64'd0);

    // Store hit: no memory traffic, read data output holds its last value.
    prev = rd;
    cpu_access(1'b1, 32'h44, 32'hDEAD_BEEF, rd, lat);
    check("st_lat", 64'(lat), 64'd2);
    check("st_traffic", 64'(log_adr.size() - base), 64'd0);
    check("dat_hold", {32'b0, rd}, {32'b0, prev});
    cpu_access(1'b0, 32'h44, '0, rd, lat);
    check("st_read_lat", 64'(lat), 64'd2);
    check("st_read_data", {32'b0, rd}, 64'hDEAD_BEEF);

    // Fill set 4 (way1 dirty via write-allocate), touch way0, then evict the oldest.
    cpu_access(1'b1, 32'h848, 32'h1111_2222, rd, lat);
    cpu_access(1'b0, 32'h1040, '0, rd, lat);
    cpu_access(1'b0, 32'h1840, '0, rd, lat);
    cpu_access(1'b0, 32'h40, '0, rd, lat);
    check("touch_lat", 64'(lat), 64'd2);
    base = log_adr.size();
    cpu_access(1'b0, 32'h2040, '0, rd, lat);
    check("evict_data", {32'b0, rd}, {32'b0, init_val(32'h2040)});
    check("evict_traffic", 64'(log_adr.size() - base), 64'd8);
    check_burst("wb_840", base, 1'b1, 32'h840);
    check("wb_dat0", {32'b0, log_dat[base]}, {32'b0, init_val(32'h840)});
    check("wb_dat2", {32'b0, log_dat[base+2]}, 64'h1111_2222);
    check_burst("refill_2040", base + 4, 1'b0, 32'h2040);
    cpu_access(1'b0, 32'h44, '0, rd, lat);
    check("survivor_lat", 64'(lat), 64'd2);
    check("survivor_data", {32'b0, rd}, 64'hDEAD_BEEF);
    base = log_adr.size();
    cpu_access(1'b0, 32'h848, '0, rd, lat);
    check("reload_data", {32'b0, rd}, 64'h1111_2222);
    check("reload_traffic", 64'(log_adr.size() - base), 64'd4);

    // Random memory latency: write-miss allocate, then a dirty eviction in set 16.
    mem_rand = 1'b1;
    base = log_adr.size();
    cpu_access(1'b1, 32'h104, 32'hCAFE_F00D, rd, lat);
    check_burst("rnd_refill_100", base, 1'b0, 32'h100);
    cpu_access(1'b0, 32'h104, '0, rd, lat);
    check("rnd_hit_data", {32'b0, rd}, 64'hCAFE_F00D);
    cpu_access(1'b0, 32'h10C, '0, rd, lat);
    check("rnd_hit_word3", {32'b0, rd}, {32'b0, init_val(32'h10C)});
    cpu_access(1'b0, 32'h900, '0, rd, lat);
    cpu_access(1'b0, 32'h1100, '0, rd, lat);
    cpu_access(1'b0, 32'h1900, '0, rd, lat);
    base = log_adr.size();
    cpu_access(1'b0, 32'h2100, '0, rd, lat);
    check("rnd_evict_traffic", 64'(log_adr.size() - base), 64'd8);
    check_burst("rnd_wb_100", base, 1'b1, 32'h100);
    check("rnd_wb_dat1", {32'b0, log_dat[base+1]}, 64'hCAFE_F00D);
    check_burst("rnd_refill_2100", base + 4, 1'b0, 32'h2100);
    check("rnd_evict_data", {32'b0, rd}, {32'b0, init_val(32'h2100)});
    check("mem_if_stable", 64'(unstable), 64'd0);
    mem_rand = 1'b0;

    // Reset while word 2 of a refill is outstanding.
    mem_fixed   = 3;
    req_cpu2cc  = 1'b1;
    rdwr_cpu2cc = 1'b0;
    adr_cpu2cc  = 32'h3040;
    found       = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (req_cc2mem && !rdwr_cc2mem && adr_cc2mem == 32'h3048) found = 1'b1;
    end
    check("abort_reached_w2", {63'b0, found}, 64'd1);
    rst        = 1'b1;
    req_cpu2cc = 1'b0;
    @(negedge clk);
    check("abort_req_low", {63'b0, req_cc2mem}, 64'd0);
    check("abort_ack_low", {63'b0, ack_cc2cpu}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", {63'b0, req_cc2mem}, 64'd0);
    base = log_adr.size();
    cpu_access(1'b0, 32'h3040, '0, rd, lat);
    check("abort_remiss", 64'(log_adr.size() - base), 64'd4);
    check_burst("abort_refill", base, 1'b0, 32'h3040);
    check("abort_data", {32'b0, rd}, {32'b0, init_val(32'h3040)});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter WAY_NUM, default 4, associativity; power of two, >=2.
REQ-004 SHALL have parameter CACHE_LINES, default 128, sets; power of two.
REQ-005 SHALL have parameter WORD_NUM, default 4, words per line; power of two, >=2.
REQ-006 Derived widths SHALL be: WOFF=log2(WORD_NUM), INDEX=log2(CACHE_LINES), TAG=ADR_WIDTH-INDEX-WOFF-2, AGE=log2(WAY_NUM).
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state on rising edge; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have CPU ports: req_cpu2cc  in  1  request; adr_cpu2cc  in  ADR_WIDTH  byte address; dat_cpu2cc  in  WORD_WIDTH  write data; rdwr_cpu2cc  in  1  0=read,1=write; ack_cc2cpu  out  1  one-cycle completion; dat_cc2cpu  out  WORD_WIDTH  read data.
REQ-009 SHALL have memory ports: req_cc2mem  out  1  request; rdwr_cc2mem  out  1  0=read,1=write; adr_cc2mem  out  ADR_WIDTH  word-aligned address; dat_cc2mem  out  WORD_WIDTH  write data; ack_mem2cc  in  1  one word done; dat_mem2cc  in  WORD_WIDTH  read data.

Function
REQ-010 Address split SHALL be {tag, index, word offset, 2-bit byte offset}; byte offset ignored.
REQ-011 CPU SHALL hold req/adr/dat/rdwr stable from request until ack_cc2cpu; ack_cc2cpu SHALL be high exactly one cycle per request.
REQ-012 States SHALL be IDLE, LOOKUP, HIT, WRITEBACK, REFILL.
REQ-013 IDLE: req_cpu2cc=1 -> LOOKUP; set tag/valid/dirty/data registered in that cycle.
REQ-014 LOOKUP: any valid way with matching tag -> HIT; else victim chosen; dirty victim -> WRITEBACK, otherwise -> REFILL.
REQ-015 Victim SHALL be lowest-numbered invalid way, else way with maximum age.
REQ-016 HIT: read drives dat_cc2cpu with addressed word and ack; write stores dat_cpu2cc into addressed word, sets dirty, acks; LRU updated; -> IDLE. Hit latency: ack 2 cycles after request sampled.
REQ-017 LRU: per-set, per-way AGE-bit counters, always a permutation of 0..WAY_NUM-1; on access to way w of age a, w->0 and every way with age<a increments.
REQ-018 WRITEBACK: WORD_NUM word writes, words 0..WORD_NUM-1 in order, rdwr_cc2mem=1, adr={victim tag,index,word,2'b00}, dat_cc2mem=victim word; req_cc2mem held until each ack; after last ack -> REFILL.
REQ-019 REFILL: WORD_NUM word reads, words 0..WORD_NUM-1, adr={tag,index,word,2'b00}; each ack writes dat_mem2cc into victim line; after last ack line marked valid, clean, tag written -> HIT (serves the pending request).
REQ-020 ack_mem2cc SHALL be ignored when req_cc2mem=0; word counter SHALL wrap to 0 after WORD_NUM-1.
REQ-021 req_cc2mem SHALL deassert in the cycle after the final ack of a burst; rdwr/adr/dat_cc2mem stable while req high.
REQ-022 Write-miss SHALL be write-allocate; no memory write on store hit (write-back).
REQ-023 dat_cc2cpu SHALL hold its last value outside read acks.

Reset
REQ-024 On rst: state IDLE; all valid and dirty bits 0; way i age = i in every set; word counter 0; ack_cc2cpu, req_cc2mem, rdwr_cc2mem 0; adr/dat_cc2mem, dat_cc2cpu 0.
REQ-025 Reset mid-operation SHALL abort any burst; req_cc2mem low the cycle after rst; dirty data discarded; data array contents unspecified.

Verification
REQ-026 After reset, read 0x0000_0040 -> LOOKUP miss, REFILL reads words 0x40,0x44,0x48,0x4C; ack_cc2cpu with dat=memory[0x40]; re-read -> hit, ack 2 cycles after req.
REQ-027 Write 0xDEADBEEF to 0x44 after that fill -> hit, no memory traffic; read 0x44 returns 0xDEADBEEF.
REQ-028 Fill all WAY_NUM ways of set 4 with distinct tags, touch way 0, access a new tag -> victim is way 1 (oldest); if dirty, 4 writes to victim address precede 4 reads.
REQ-029 Memory ack delayed 0..5 random cycles per word -> outputs stable while req high, burst order 0..3 preserved, no dropped words.
REQ-030 Assert rst during REFILL word 2 -> req_cc2mem=0 next cycle, state IDLE, subsequent access to same address misses.
